// File: rtl/count_event_monitor.sv
// count_event_monitor
//
// Watches the output of a loadable up-counter, classifies every
// transition it sees and queues one event record per cycle into a small
// first-word-fall-through FIFO. The FIFO is drained over a valid/ready
// handshake. A running count of wraps and a sticky flag for dropped events
// are kept alongside.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   count_in   in   W      counter value under observation
//   match_en   in   1      enables MATCH events
//   match_val  in   W      compare value for MATCH
//   evt_valid  out  1      FIFO non-empty, head record on evt_data
//   evt_ready  in   1      consumer takes the head when evt_valid & evt_ready
//   evt_data   out  2+W    {type, count}: 01 WRAP, 10 JUMP, 11 MATCH; 0 when empty
//   wrap_cnt   out  WCW    WRAP events seen (queued or dropped), modulo 2^WCW
//   ovf        out  1      sticky: an event was lost to a full FIFO
//   ovf_clr    in   1      clears ovf; a drop in the same cycle wins
module count_event_monitor #(
   parameter int W     = 4,
   parameter int DEPTH = 4,
   parameter int WCW   = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   count_in,
   input  logic           match_en,
   input  logic [W-1:0]   match_val,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [W+1:0]   evt_data,
   output logic [WCW-1:0] wrap_cnt,
   output logic           ovf,
   input  logic           ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] TYP_NONE  = 2'b00;
   localparam logic [1:0] TYP_WRAP  = 2'b01;
   localparam logic [1:0] TYP_JUMP  = 2'b10;
   localparam logic [1:0] TYP_MATCH = 2'b11;

   // Priority is WRAP > JUMP > MATCH; a held value never produces an event.
   function automatic logic [1:0] classify(
      input logic [W-1:0] prev_v,
      input logic [W-1:0] cur_v,
      input logic         men_v,
      input logic [W-1:0] mval_v
   );
      logic [W-1:0] succ;
      logic [1:0]   typ;
      succ = prev_v + W'(1);
      typ  = TYP_NONE;
      if (prev_v == {W{1'b1}} && cur_v == '0)
         typ = TYP_WRAP;
      else if (cur_v != prev_v && cur_v != succ)
         typ = TYP_JUMP;
      else if (men_v && cur_v == mval_v && cur_v != prev_v)
         typ = TYP_MATCH;
      return typ;
   endfunction

   logic [W-1:0]   prev;
   logic           prev_vld;
   logic [W+1:0]   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  fill;

   logic [1:0]     evt_type;
   logic [W+1:0]   rec;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           wr_en;
   logic           drop;

   // Classification stage: compare the value sampled now against the last one
   assign evt_type = prev_vld ? classify(prev, count_in, match_en, match_val) : TYP_NONE;
   assign rec      = {evt_type, count_in};
   assign push     = (evt_type != TYP_NONE);

   // FIFO control: when full, a simultaneous pop frees the slot being written
   assign empty    = (fill == '0);
   assign full     = (fill == CW'(DEPTH));
   assign pop      = ~empty & evt_ready;
   assign wr_en    = push & (~full | pop);
   assign drop     = push & full & ~pop;

   assign evt_valid = ~empty;
   assign evt_data  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_vld <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fill     <= '0;
         wrap_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         prev_vld <= 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   fill <= fill + CW'(1);
            2'b01:   fill <= fill - CW'(1);
            default: fill <= fill;
         endcase
         // Wraps are counted even when the record itself is dropped.
         if (evt_type == TYP_WRAP)
            wrap_cnt <= wrap_cnt + WCW'(1);
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   // Storage stage: data registers carry no reset, validity lives in control
   always_ff @(posedge clk) begin
      prev <= count_in;
      if (wr_en)
         mem[wr_ptr] <= rec;
   end

endmodule
